// File: rtl/audio_adc_serial_rx_pkg.sv
// Shared types and helpers for the audio ADC serial receiver.
package audio_adc_serial_rx_pkg;

  localparam int ADC_BITS = 16;  // SCLK periods per conversion frame
  localparam int ADC_RES  = 12;  // significant sample bits at the LSB end of a frame

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_QUIET    = 3'd4
  } adc_state_e;

  // Left-justify the 12-bit sample so its MSBs land at the top of the word,
  // or pass the raw frame through unchanged.
  function automatic logic [ADC_BITS-1:0] justify_sample(input logic [ADC_BITS-1:0] raw,
                                                         input logic              left_just);
    logic [ADC_BITS-1:0] res;
    if (left_just) begin
      res = {raw[ADC_RES-1:0], {(ADC_BITS-ADC_RES){1'b0}}};
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/audio_adc_serial_rx_sclk_div.sv
// Reloadable down-counter producing one tick per timed interval of the frame.
module adc_sclk_div #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] cnt_r;

  assign tick = (cnt_r == {W{1'b0}});

  // Count down, reloading on an explicit load or when the interval expires.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= {W{1'b0}};
    end else if (load || tick) begin
      cnt_r <= load_val;
    end else begin
      cnt_r <= cnt_r - W'(1);
    end
  end

endmodule

// File: rtl/audio_adc_serial_rx.sv
// Framed serial receiver for an AD7476-class audio ADC: one request, one
// 16-SCLK frame, one justified sample with a level dat_valid.
module audio_adc_serial_rx
  import audio_adc_serial_rx_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int QUIET_CYCLES = 8,
  parameter bit LEFT_JUSTIFY = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start_conv,
  input  logic                SDATA,
  output logic                cs,
  output logic                sclk,
  output logic [ADC_BITS-1:0] data_out,
  output logic                ready,
  output logic                dat_valid
);

  localparam int DIV_MAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
  localparam int CNT_W   = $clog2(DIV_MAX) + 1;

  adc_state_e          state_r, state_nxt_s;
  logic                cs_r, cs_nxt_s;
  logic                sclk_r, sclk_nxt_s;
  logic                ready_r, ready_nxt_s;
  logic                valid_r, valid_nxt_s;
  logic [ADC_BITS-1:0] data_r, data_nxt_s;
  logic [ADC_BITS-1:0] shreg_r, shreg_nxt_s;
  logic [4:0]          bit_cnt_r, bit_cnt_nxt_s;
  logic                div_load_s;
  logic [CNT_W-1:0]    div_val_s;
  logic                tick_s;

  // Hold the divider loaded while idle; the quiet interval uses its own reload.
  always_comb begin
    div_load_s = (state_r == ST_IDLE);
    if (state_r == ST_CS_HOLD) begin
      div_val_s = CNT_W'(QUIET_CYCLES - 1);
    end else begin
      div_val_s = CNT_W'(CLK_DIV - 1);
    end
  end

  adc_sclk_div #(.W(CNT_W)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .load     (div_load_s),
    .load_val (div_val_s),
    .tick     (tick_s)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; each timed state advances on the divider tick.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:     if (start_conv) state_nxt_s = ST_CS_SETUP; else state_nxt_s = ST_IDLE;
      ST_CS_SETUP: if (tick_s) state_nxt_s = ST_SHIFT; else state_nxt_s = ST_CS_SETUP;
      ST_SHIFT:    if (tick_s && !sclk_r && (bit_cnt_r == 5'd15)) state_nxt_s = ST_CS_HOLD;
                   else state_nxt_s = ST_SHIFT;
      ST_CS_HOLD:  if (tick_s) state_nxt_s = ST_QUIET; else state_nxt_s = ST_CS_HOLD;
      ST_QUIET:    if (tick_s) state_nxt_s = ST_IDLE; else state_nxt_s = ST_QUIET;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the interface and datapath registers.
  always_comb begin
    cs_nxt_s      = cs_r;
    sclk_nxt_s    = sclk_r;
    ready_nxt_s   = ready_r;
    valid_nxt_s   = valid_r;
    data_nxt_s    = data_r;
    shreg_nxt_s   = shreg_r;
    bit_cnt_nxt_s = bit_cnt_r;
    case (state_r)
      ST_IDLE: begin
        cs_nxt_s    = 1'b1;
        sclk_nxt_s  = 1'b1;
        ready_nxt_s = 1'b1;
        if (start_conv) begin
          cs_nxt_s      = 1'b0;
          ready_nxt_s   = 1'b0;
          valid_nxt_s   = 1'b0;
          shreg_nxt_s   = {ADC_BITS{1'b0}};
          bit_cnt_nxt_s = 5'd0;
        end else begin
          valid_nxt_s = valid_r;
        end
      end
      ST_CS_SETUP: begin
        if (tick_s) sclk_nxt_s = 1'b0; else sclk_nxt_s = sclk_r;
      end
      ST_SHIFT: begin
        if (tick_s) begin
          sclk_nxt_s = ~sclk_r;
          // SDATA is taken on the rising SCLK edge, half a period after the ADC launched it.
          if (!sclk_r) begin
            shreg_nxt_s   = {shreg_r[ADC_BITS-2:0], SDATA};
            bit_cnt_nxt_s = bit_cnt_r + 5'd1;
          end else begin
            shreg_nxt_s = shreg_r;
          end
        end else begin
          sclk_nxt_s = sclk_r;
        end
      end
      ST_CS_HOLD: begin
        if (tick_s) begin
          cs_nxt_s    = 1'b1;
          data_nxt_s  = justify_sample(shreg_r, LEFT_JUSTIFY);
          valid_nxt_s = 1'b1;
        end else begin
          cs_nxt_s = cs_r;
        end
      end
      ST_QUIET: begin
        if (tick_s) ready_nxt_s = 1'b1; else ready_nxt_s = ready_r;
      end
      default: begin
        cs_nxt_s    = 1'b1;
        sclk_nxt_s  = 1'b1;
        ready_nxt_s = 1'b1;
      end
    endcase
  end

  // Interface and datapath registers; reset returns cs/sclk high at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cs_r      <= 1'b1;
      sclk_r    <= 1'b1;
      ready_r   <= 1'b1;
      valid_r   <= 1'b0;
      data_r    <= {ADC_BITS{1'b0}};
      shreg_r   <= {ADC_BITS{1'b0}};
      bit_cnt_r <= 5'd0;
    end else begin
      cs_r      <= cs_nxt_s;
      sclk_r    <= sclk_nxt_s;
      ready_r   <= ready_nxt_s;
      valid_r   <= valid_nxt_s;
      data_r    <= data_nxt_s;
      shreg_r   <= shreg_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
    end
  end

  assign cs        = cs_r;
  assign sclk      = sclk_r;
  assign ready     = ready_r;
  assign dat_valid = valid_r;
  assign data_out  = data_r;

endmodule

// File: tb/tb_audio_adc_serial_rx.sv
// Directed bench for audio_adc_serial_rx with a behavioural ADC model.
module tb_audio_adc_serial_rx;

  logic        clk;
  logic        resetn;
  logic        start_conv;
  logic        sdata;
  logic        cs;
  logic        sclk;
  logic [15:0] data_out;
  logic        ready;
  logic        dat_valid;

  int unsigned n_total;
  int unsigned n_pass;
  int          rises;
  logic [15:0] adc_word;
  logic [15:0] last_data;
  int          adc_idx;

  typedef struct {
    logic [15:0] sample;
    logic [15:0] exp_data;
    int          glitch;  // edge at which a stray start_conv pulse is issued, -1 none
    bit          hold;    // keep start_conv high to chain frames
  } vec_t;

  vec_t vecs [6];

  audio_adc_serial_rx #(
    .CLK_DIV      (4),
    .QUIET_CYCLES (8),
    .LEFT_JUSTIFY (1'b1)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start_conv (start_conv),
    .SDATA      (sdata),
    .cs         (cs),
    .sclk       (sclk),
    .data_out   (data_out),
    .ready      (ready),
    .dat_valid  (dat_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model: cs fall presents the MSB, each SCLK fall presents the next bit.
  always @(negedge cs or negedge sclk) begin
    if (sclk) begin
      adc_idx = 15;
      sdata   = adc_word[15];
    end else if (!cs) begin
      if (adc_idx >= 0) begin
        sdata   = adc_word[adc_idx];
        adc_idx = adc_idx - 1;
      end
    end
  end

  // Count SCLK rising edges seen while the ADC is selected.
  always @(posedge sclk) begin
    if (!cs) rises = rises + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic do_frame(input logic [15:0] sample, input logic [15:0] exp,
                          input int glitch, input bit hold);
    int  v_edge;
    int  r_edge;
    bit  stable;
    adc_word = sample;
    rises    = 0;
    @(negedge clk) start_conv = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_cs_ready_valid", {29'd0, cs, ready, dat_valid}, 32'd0);
    v_edge = -1;
    r_edge = -1;
    stable = 1'b1;
    for (int e = 1; e <= 400 && r_edge < 0; e++) begin
      @(negedge clk) start_conv = hold | (e == glitch);
      @(posedge clk);
      #1;
      if (dat_valid && v_edge < 0) v_edge = e;
      if (v_edge < 0 && data_out !== last_data) stable = 1'b0;
      if (ready) r_edge = e;
    end
    chk("data_stable_in_frame", {31'd0, stable}, 32'd1);
    chk("valid_edge", v_edge, 32'd132);
    chk("ready_edge", r_edge, 32'd140);
    chk("data_out", {16'd0, data_out}, {16'd0, exp});
    chk("sclk_rises", rises, 32'd16);
    last_data = exp;
    if (!hold) begin
      repeat (3) @(posedge clk);
      #1;
      chk("idle_after_frame", {29'd0, cs, sclk, ready}, 32'd7);
      chk("valid_held", {31'd0, dat_valid}, 32'd1);
    end
  endtask

  initial begin
    n_total    = 0;
    n_pass     = 0;
    rises      = 0;
    adc_idx    = 15;
    adc_word   = 16'h0000;
    sdata      = 1'b0;
    last_data  = 16'h0000;
    start_conv = 1'b0;
    resetn     = 1'b0;

    vecs[0] = '{sample: 16'h0ABC, exp_data: 16'hABC0, glitch: -1, hold: 1'b0};
    vecs[1] = '{sample: 16'h0A5A, exp_data: 16'hA5A0, glitch: 50, hold: 1'b0};
    vecs[2] = '{sample: 16'h0FFF, exp_data: 16'hFFF0, glitch: -1, hold: 1'b1};
    vecs[3] = '{sample: 16'h0001, exp_data: 16'h0010, glitch: -1, hold: 1'b1};
    vecs[4] = '{sample: 16'h0800, exp_data: 16'h8000, glitch: -1, hold: 1'b0};
    vecs[5] = '{sample: 16'h0000, exp_data: 16'h0000, glitch: -1, hold: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", {31'd0, cs}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd1);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_valid", {31'd0, dat_valid}, 32'd0);
    chk("rst_data", {16'd0, data_out}, 32'd0);
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      do_frame(vecs[i].sample, vecs[i].exp_data, vecs[i].glitch, vecs[i].hold);
    end

    // Reset in the middle of a frame
    adc_word = 16'h0ABC;
    @(negedge clk) start_conv = 1'b1;
    @(posedge clk);
    @(negedge clk) start_conv = 1'b0;
    repeat (69) @(posedge clk);
    #1;
    chk("midframe_cs_low", {30'd0, cs, sclk}, 32'd0);
    #1 resetn = 1'b0;
    #1;
    chk("midrst_cs", {31'd0, cs}, 32'd1);
    chk("midrst_sclk", {31'd0, sclk}, 32'd1);
    chk("midrst_data", {16'd0, data_out}, 32'd0);
    chk("midrst_valid", {31'd0, dat_valid}, 32'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {31'd0, ready}, 32'd1);
    last_data = 16'h0000;
    do_frame(16'h0123, 16'h1230, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
